match_score_ctrl: RTL and testbench
===================================

MATCH_SCORE_CTRL -- requirements
Module: match_score_ctrl

Interface
REQ-001 Parameter: WIN_TARGET, default 3, round wins needed to take the match; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 play  input  1  player "play" button, level, already debounced and synchronous to clk.
REQ-005 new_match  input  1  one-cycle request to clear scores and start a new match.
REQ-006 pa  input  1  judge result: player A wins the current round.
REQ-007 pb  input  1  judge result: player B wins the current round.
REQ-008 e  input  1  judge result: current round is a tie.
REQ-009 score_a  output  3  rounds won by A in the current match.
REQ-010 score_b  output  3  rounds won by B in the current match.
REQ-011 ties  output  4  tied rounds in the current match, saturating.
REQ-012 round_done  output  1  one-cycle pulse: a round was evaluated.
REQ-013 bad_round  output  1  one-cycle pulse, coincident with round_done: round rejected.
REQ-014 match_over  output  1  level: a player reached WIN_TARGET.
REQ-015 winner_a  output  1  level, valid while match_over: A won the match.
REQ-016 winner_b  output  1  level, valid while match_over: B won the match.

Function
REQ-017 FSM states: IDLE, EVAL, HOLD, OVER; all outputs are registered.
REQ-018 Internal play_q register holds play from the previous cycle; rising edge = play & ~play_q.
REQ-019 IDLE -> EVAL on the cycle a rising edge of play is seen; otherwise stay in IDLE.
REQ-020 EVAL lasts exactly one cycle; pa, pb, e are sampled on the EVAL cycle's closing edge.
REQ-021 Valid round: exactly one of pa, pb, e is 1; anything else (none or more than one) is a bad round.
REQ-022 Valid pa: score_a +1; valid pb: score_b +1; valid e: ties +1, saturating at 15; bad round: no counter changes.
REQ-023 round_done is 1 for exactly the one cycle after EVAL; bad_round is 1 in that same cycle only for a bad round.
REQ-024 Counter updates become visible in the same cycle as round_done; latency from the play edge cycle is 2 cycles.
REQ-025 EVAL -> OVER if the updated score_a or score_b equals WIN_TARGET; otherwise EVAL -> HOLD.
REQ-026 HOLD -> IDLE on the first cycle play = 0, so one press scores at most one round.
REQ-027 OVER: match_over = 1; winner_a / winner_b set from whichever score hit WIN_TARGET; scores and ties frozen.
REQ-028 OVER: play edges are ignored; no round_done pulses are produced.
REQ-029 new_match = 1 in any state: next cycle score_a = score_b = ties = 0, match_over = winner_a = winner_b = 0, state IDLE.
REQ-030 new_match on the EVAL cycle: the round is discarded and no round_done is produced.
REQ-031 winner_a and winner_b are never both 1; scores never exceed WIN_TARGET.
REQ-032 A play edge whose press is still held when the FSM re-enters IDLE is not counted again; a new press requires play to fall and rise.

Reset
REQ-033 rst = 1 at a clock edge: state IDLE, play_q = 1, all counters 0, all outputs 0.
REQ-034 rst has priority over new_match and play; asserting rst mid-round (EVAL or HOLD) discards the round with no round_done.
REQ-035 play_q resets to 1, so a button held through reset release does not start a round.

Verification
REQ-036 After rst, press play with pa = 1: round_done pulses 2 cycles after the press edge, score_a = 1, bad_round = 0.
REQ-037 Press with pa = pb = 1, then press with all zero: two round_done pulses, both with bad_round = 1, all counters unchanged.
REQ-038 WIN_TARGET = 3, three pb presses: match_over = 1, winner_b = 1, score_b = 3; a fourth press produces no round_done.
REQ-039 Sixteen e presses: ties = 15 and stays 15, with a round_done on every press.
REQ-040 Hold play high for 10 cycles with pa = 1: exactly one round_done and score_a = 1; release and press again: score_a = 2.
REQ-041 Assert new_match in OVER, and separately in EVAL: next cycle all counters and flags are 0, no round_done, FSM in IDLE.

Source files
------------

// File: rtl/match_score_ctrl_if.sv
// ============================================================================
// Module   : match_score_ctrl_if
// Purpose  : Button/judge inputs and score/status outputs of the match controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface match_score_ctrl_if;
  logic       play;
  logic       new_match;
  logic       pa;
  logic       pb;
  logic       e;
  logic [2:0] score_a;
  logic [2:0] score_b;
  logic [3:0] ties;
  logic       round_done;
  logic       bad_round;
  logic       match_over;
  logic       winner_a;
  logic       winner_b;

  modport master (
    output play, new_match, pa, pb, e,
    input  score_a, score_b, ties, round_done, bad_round,
    input  match_over, winner_a, winner_b
  );

  modport slave (
    input  play, new_match, pa, pb, e,
    output score_a, score_b, ties, round_done, bad_round,
    output match_over, winner_a, winner_b
  );
endinterface

`default_nettype wire

// File: rtl/match_score_ctrl.sv
// ============================================================================
// Module   : match_score_ctrl
// Purpose  : Round-by-round scorekeeper; a play press triggers one judged round.
// Revision : 1.0
// ============================================================================
`default_nettype none

module match_score_ctrl #(
  parameter int WIN_TARGET = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  match_score_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [2:0] c_win_target = 3'(WIN_TARGET);

  state_t     state_q;
  logic       play_q;
  logic [2:0] score_a_q;
  logic [2:0] score_b_q;
  logic [3:0] ties_q;
  logic       round_done_q;
  logic       bad_round_q;
  logic       match_over_q;
  logic       winner_a_q;
  logic       winner_b_q;

  logic       valid_d;
  logic [2:0] score_a_d;
  logic [2:0] score_b_d;
  logic [3:0] ties_d;

  // Exactly one of three bits set: odd parity, but not all three.
  always_comb begin
    valid_d   = (bus.pa ^ bus.pb ^ bus.e) & ~(bus.pa & bus.pb & bus.e);
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    ties_d    = ties_q;
    if (valid_d && bus.pa) score_a_d = score_a_q + 3'd1;
    if (valid_d && bus.pb) score_b_d = score_b_q + 3'd1;
    if (valid_d && bus.e && (ties_q != 4'hF)) ties_d = ties_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      play_q       <= 1'b1;
      score_a_q    <= 3'd0;
      score_b_q    <= 3'd0;
      ties_q       <= 4'd0;
      round_done_q <= 1'b0;
      bad_round_q  <= 1'b0;
      match_over_q <= 1'b0;
      winner_a_q   <= 1'b0;
      winner_b_q   <= 1'b0;
    end else begin
      play_q       <= bus.play;
      round_done_q <= 1'b0;
      bad_round_q  <= 1'b0;
      if (bus.new_match) begin
        state_q      <= S_IDLE;
        score_a_q    <= 3'd0;
        score_b_q    <= 3'd0;
        ties_q       <= 4'd0;
        match_over_q <= 1'b0;
        winner_a_q   <= 1'b0;
        winner_b_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (bus.play && !play_q) state_q <= S_EVAL;
          S_EVAL: begin
            round_done_q <= 1'b1;
            bad_round_q  <= ~valid_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            ties_q       <= ties_d;
            if ((score_a_d == c_win_target) || (score_b_d == c_win_target)) begin
              state_q      <= S_OVER;
              match_over_q <= 1'b1;
              winner_a_q   <= (score_a_d == c_win_target);
              winner_b_q   <= (score_b_d == c_win_target);
            end else begin
              state_q <= S_HOLD;
            end
          end
          // Wait for release so a long press cannot score twice.
          S_HOLD: if (!bus.play) state_q <= S_IDLE;
          S_OVER: state_q <= S_OVER;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.score_a    = score_a_q;
  assign bus.score_b    = score_b_q;
  assign bus.ties       = ties_q;
  assign bus.round_done = round_done_q;
  assign bus.bad_round  = bad_round_q;
  assign bus.match_over = match_over_q;
  assign bus.winner_a   = winner_a_q;
  assign bus.winner_b   = winner_b_q;

endmodule

`default_nettype wire

// File: tb/tb_match_score_ctrl.sv
// ============================================================================
// Module   : tb_match_score_ctrl
// Purpose  : Directed self-checking bench for match_score_ctrl (WIN_TARGET = 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_match_score_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  match_score_ctrl_if bus ();

  match_score_ctrl #(.WIN_TARGET(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One button press with fixed judge inputs; counts pulses seen while held and after release.
  task automatic press(input logic a, input logic b, input logic t, input int hi,
                       output int nrd, output int nbad);
    nrd  = 0;
    nbad = 0;
    bus.pa   = a;
    bus.pb   = b;
    bus.e    = t;
    bus.play = 1'b1;
    for (int i = 0; i < hi; i++) begin
      tick();
      if (bus.round_done === 1'b1) nrd++;
      if (bus.bad_round === 1'b1) nbad++;
    end
    bus.play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.round_done === 1'b1) nrd++;
      if (bus.bad_round === 1'b1) nbad++;
    end
    bus.pa = 1'b0;
    bus.pb = 1'b0;
    bus.e  = 1'b0;
  endtask

  task automatic pulse_new_match();
    bus.new_match = 1'b1;
    tick();
    bus.new_match = 1'b0;
  endtask

  task automatic test_reset();
    int nrd;
    rst = 1'b1;
    bus.play = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.score_a, bus.score_b, bus.ties} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_counters actual=%0h required=0", {bus.score_a, bus.score_b, bus.ties});
    end
    n_checks++;
    if ({bus.round_done, bus.bad_round, bus.match_over, bus.winner_a, bus.winner_b} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_flags actual=%b required=00000",
               {bus.round_done, bus.bad_round, bus.match_over, bus.winner_a, bus.winner_b});
    end
    rst = 1'b0;
    nrd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.round_done === 1'b1) nrd++;
    end
    n_checks++;
    if (nrd !== 0) begin
      n_fail++;
      $display("FAIL reset_held_play_rounds actual=%0d required=0", nrd);
    end
    bus.play = 1'b0;
    tick();
  endtask

  task automatic test_first_round();
    bus.pa   = 1'b1;
    bus.play = 1'b1;
    tick();
    n_checks++;
    if (bus.round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL first_early_done actual=%b required=0", bus.round_done);
    end
    tick();
    n_checks++;
    if ({bus.round_done, bus.bad_round} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_done_bad actual=%b required=10", {bus.round_done, bus.bad_round});
    end
    n_checks++;
    if (bus.score_a !== 3'd1) begin
      n_fail++;
      $display("FAIL first_score_a actual=%0d required=1", bus.score_a);
    end
    bus.play = 1'b0;
    bus.pa   = 1'b0;
    tick();
    n_checks++;
    if (bus.round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL first_done_width actual=%b required=0", bus.round_done);
    end
    tick();
  endtask

  task automatic test_bad_rounds();
    int nrd, nbad;
    press(1'b1, 1'b1, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || nbad !== 1) begin
      n_fail++;
      $display("FAIL bad_two_set actual=%0d/%0d required=1/1", nrd, nbad);
    end
    press(1'b0, 1'b0, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || nbad !== 1) begin
      n_fail++;
      $display("FAIL bad_none_set actual=%0d/%0d required=1/1", nrd, nbad);
    end
    n_checks++;
    if ({bus.score_a, bus.score_b, bus.ties} !== {3'd1, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL bad_counters actual=%0d/%0d/%0d required=1/0/0", bus.score_a, bus.score_b, bus.ties);
    end
  endtask

  task automatic test_hold_long();
    int nrd, nbad;
    pulse_new_match();
    press(1'b1, 1'b0, 1'b0, 10, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || bus.score_a !== 3'd1) begin
      n_fail++;
      $display("FAIL hold_long actual=%0d/%0d required=1/1", nrd, bus.score_a);
    end
    press(1'b1, 1'b0, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || bus.score_a !== 3'd2) begin
      n_fail++;
      $display("FAIL hold_repress actual=%0d/%0d required=1/2", nrd, bus.score_a);
    end
  endtask

  task automatic test_eval_new_match();
    int nrd, nbad;
    bus.pa   = 1'b1;
    bus.play = 1'b1;
    tick();
    bus.new_match = 1'b1;
    tick();
    bus.new_match = 1'b0;
    n_checks++;
    if ({bus.round_done, bus.score_a, bus.match_over} !== 5'd0) begin
      n_fail++;
      $display("FAIL eval_nm_clear actual=%b required=00000", {bus.round_done, bus.score_a, bus.match_over});
    end
    nrd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.round_done === 1'b1) nrd++;
    end
    n_checks++;
    if (nrd !== 0) begin
      n_fail++;
      $display("FAIL eval_nm_late_done actual=%0d required=0", nrd);
    end
    bus.play = 1'b0;
    bus.pa   = 1'b0;
    tick();
    press(1'b1, 1'b0, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || bus.score_a !== 3'd1) begin
      n_fail++;
      $display("FAIL eval_nm_idle_after actual=%0d/%0d required=1/1", nrd, bus.score_a);
    end
  endtask

  task automatic test_ties();
    int nrd, nbad, tot_rd, tot_bad;
    pulse_new_match();
    tot_rd  = 0;
    tot_bad = 0;
    for (int k = 0; k < 16; k++) begin
      press(1'b0, 1'b0, 1'b1, 2, nrd, nbad);
      tot_rd  += nrd;
      tot_bad += nbad;
      if (k == 14) begin
        n_checks++;
        if (bus.ties !== 4'd15) begin
          n_fail++;
          $display("FAIL ties_at_15 actual=%0d required=15", bus.ties);
        end
      end
    end
    n_checks++;
    if (bus.ties !== 4'd15) begin
      n_fail++;
      $display("FAIL ties_saturate actual=%0d required=15", bus.ties);
    end
    n_checks++;
    if (tot_rd !== 16 || tot_bad !== 0) begin
      n_fail++;
      $display("FAIL ties_pulses actual=%0d/%0d required=16/0", tot_rd, tot_bad);
    end
  endtask

  task automatic test_match_b();
    int nrd, nbad;
    pulse_new_match();
    press(1'b0, 1'b1, 1'b0, 2, nrd, nbad);
    press(1'b0, 1'b1, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (bus.match_over !== 1'b0 || bus.score_b !== 3'd2) begin
      n_fail++;
      $display("FAIL matchb_early_over actual=%b/%0d required=0/2", bus.match_over, bus.score_b);
    end
    press(1'b0, 1'b1, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 1 || {bus.match_over, bus.winner_a, bus.winner_b} !== 3'b101 || bus.score_b !== 3'd3) begin
      n_fail++;
      $display("FAIL matchb_over actual=%0d/%b/%0d required=1/101/3",
               nrd, {bus.match_over, bus.winner_a, bus.winner_b}, bus.score_b);
    end
    press(1'b0, 1'b1, 1'b0, 2, nrd, nbad);
    n_checks++;
    if (nrd !== 0 || bus.score_b !== 3'd3 || bus.match_over !== 1'b1) begin
      n_fail++;
      $display("FAIL matchb_frozen actual=%0d/%0d/%b required=0/3/1", nrd, bus.score_b, bus.match_over);
    end
  endtask

  task automatic test_over_new_match();
    pulse_new_match();
    n_checks++;
    if ({bus.score_a, bus.score_b, bus.ties, bus.round_done, bus.match_over, bus.winner_a, bus.winner_b} !== 14'd0) begin
      n_fail++;
      $display("FAIL over_nm_clear actual=%b required=0",
               {bus.score_a, bus.score_b, bus.ties, bus.round_done, bus.match_over, bus.winner_a, bus.winner_b});
    end
  endtask

  task automatic test_match_a();
    int nrd, nbad;
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0, 2, nrd, nbad);
    n_checks++;
    if ({bus.match_over, bus.winner_a, bus.winner_b} !== 3'b110 || bus.score_a !== 3'd3 || bus.score_b !== 3'd0) begin
      n_fail++;
      $display("FAIL matcha_over actual=%b/%0d/%0d required=110/3/0",
               {bus.match_over, bus.winner_a, bus.winner_b}, bus.score_a, bus.score_b);
    end
  endtask

  task automatic test_rst_mid_round();
    int nrd;
    pulse_new_match();
    bus.pa   = 1'b1;
    bus.play = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nrd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.round_done === 1'b1) nrd++;
    end
    n_checks++;
    if (nrd !== 0 || bus.score_a !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_round actual=%0d/%0d required=0/0", nrd, bus.score_a);
    end
    bus.play = 1'b0;
    bus.pa   = 1'b0;
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.play      = 1'b0;
    bus.new_match = 1'b0;
    bus.pa        = 1'b0;
    bus.pb        = 1'b0;
    bus.e         = 1'b0;
    test_reset();
    test_first_round();
    test_bad_rounds();
    test_hold_long();
    test_eval_new_match();
    test_ties();
    test_match_b();
    test_over_new_match();
    test_match_a();
    test_rst_mid_round();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
